// File: rtl/phase_readout_ctrl_if.sv
// FIFO read port and SPI serializer handshake of the phase readout controller.
// master: controller side; slave: FIFO / serializer side.
interface phase_readout_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  spi_go;
    logic [DATA_WIDTH-1:0] spi_data;
    logic                  spi_ss_n;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  spi_ss_n,
        output fifo_rd_en,
        output spi_go,
        output spi_data
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output spi_ss_n,
        input  fifo_rd_en,
        input  spi_go,
        input  spi_data
    );
endinterface

// File: rtl/phase_readout_ctrl.sv
// Phase readout controller: pops FIFO words and hands them to an SPI serializer,
// one frame at a time. Optional macro PHASE_READOUT_SEQ_TAG_EN tags frames with a sequence nibble.
module phase_readout_ctrl #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    phase_readout_ctrl_if.master bus,
    output logic                 busy,
    output logic [15:0]          frame_count,
    output logic                 timeout_err
);
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned WAIT_LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;
    localparam int unsigned GAP_LAST  = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned TMO_LAST  = (START_TIMEOUT > 1) ? START_TIMEOUT - 1 : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_DATA,
        LOAD,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  capture, tmo_set, frame_done;
    logic                  rd_en_q, go_q;
    logic [DATA_WIDTH-1:0] spi_data_q;
    logic [DATA_WIDTH-1:0] load_word;

`ifdef PHASE_READOUT_SEQ_TAG_EN
    logic unused_tag_hi;
    assign unused_tag_hi = ^bus.fifo_data[DATA_WIDTH-1:DATA_WIDTH-4];
    assign load_word     = {frame_count[3:0], bus.fifo_data[DATA_WIDTH-5:0]};
`else
    assign load_word     = bus.fifo_data;
`endif

    // State and shared cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; the start timer is preloaded in LOAD so the flag rises START_TIMEOUT cycles after spi_go
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        capture    = 1'b0;
        tmo_set    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !bus.fifo_empty) state_nxt = READ;
            end
            READ: begin
                cnt_nxt   = '0;
                state_nxt = (READ_LATENCY > 1) ? WAIT_DATA : LOAD;
            end
            WAIT_DATA: begin
                if (cnt >= CNT_W'(WAIT_LAST)) state_nxt = LOAD;
                else                          cnt_nxt   = cnt + CNT_W'(1);
            end
            LOAD: begin
                capture   = 1'b1;
                cnt_nxt   = CNT_W'(1);
                state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (!bus.spi_ss_n) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt >= CNT_W'(TMO_LAST)) begin
                    tmo_set   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (bus.spi_ss_n) begin
                    frame_done = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = GAP;
                end
            end
            GAP: begin
                if (cnt >= CNT_W'(GAP_LAST)) state_nxt = IDLE;
                else                         cnt_nxt   = cnt + CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, aligned with the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q     <= 1'b0;
            go_q        <= 1'b0;
            busy        <= 1'b0;
            spi_data_q  <= '0;
            frame_count <= 16'h0000;
            timeout_err <= 1'b0;
        end else begin
            rd_en_q <= (state_nxt == READ);
            go_q    <= (state_nxt == LOAD);
            busy    <= (state_nxt != IDLE);
            if (capture)    spi_data_q  <= load_word;
            if (frame_done) frame_count <= frame_count + 16'd1;
            if (tmo_set)    timeout_err <= 1'b1;
        end
    end

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.spi_go     = go_q;
    assign bus.spi_data   = spi_data_q;
endmodule

// File: tb/tb_phase_readout_ctrl.sv
// Randomized bench for phase_readout_ctrl against a queue-based FIFO/serializer reference model.
module tb_phase_readout_ctrl;
    localparam int unsigned DW        = 16;
    localparam int unsigned RL        = 2;
    localparam int unsigned GAP       = 4;
    localparam int unsigned TMO       = 8;
    localparam int          FRAME_LEN = 16;
`ifdef PHASE_READOUT_SEQ_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        busy;
    logic        timeout_err;
    logic [15:0] frame_count;

    phase_readout_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    phase_readout_ctrl #(
        .DATA_WIDTH(DW), .READ_LATENCY(RL), .GAP_CYCLES(GAP), .START_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus),
        .busy(busy), .frame_count(frame_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pend_word = '0;
    logic [DW-1:0] exp_data = '0;
    bit pend = 0, ser_active = 0, ser_respond = 1, tmo_pending = 0, tmo_flag = 0, have_end = 0;
    int pend_due = 0, rd_cyc = -1000, go_cyc = 0, ss_fall = 0, ss_rise = 0, data_chk_cyc = -1;
    int model_count = 0, last_end = 0, rd_count = 0, go_count = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] expect_word(input logic [DW-1:0] w, input int n);
        logic [3:0] tag;
        tag = 4'(n % 16);
        return TAG_EN ? {tag, w[DW-5:0]} : w;
    endfunction

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // Observe the cycle just completed, then drive the FIFO/serializer models for the next edge
    task automatic monitor();
        if (bus.fifo_rd_en) begin
            rd_count++;
            check("rd_while_empty", 64'(bus.fifo_empty), 0);
            check("rd_while_disabled", 64'(enable), 1);
            check("rd_during_rst", 64'(rst), 0);
            check("rd_go_overlap", 64'(bus.spi_go), 0);
            if (have_end) check("rd_spacing", 64'(cyc - last_end >= int'(GAP) + 2), 1);
            if (fifo_q.size() == 0) begin
                check("fifo_underflow", 1, 0);
            end else begin
                pend_word = fifo_q.pop_front();
                pend      = 1;
                pend_due  = cyc + int'(RL);
                rd_cyc    = cyc;
            end
        end
        if (bus.spi_go) begin
            go_count++;
            check("go_latency", 64'(cyc - rd_cyc), 64'(RL));
            check("go_during_rst", 64'(rst), 0);
            check("busy_at_go", 64'(busy), 1);
            check("count_at_go", 64'(frame_count), 64'(model_count));
            exp_data     = expect_word(pend_word, model_count);
            go_cyc       = cyc;
            data_chk_cyc = cyc + 1;
            if (ser_respond) begin
                ser_active = 1;
                ss_fall    = cyc + 2;
                ss_rise    = cyc + 2 + FRAME_LEN;
            end else begin
                tmo_pending = 1;
            end
        end
        if (cyc == data_chk_cyc) check("spi_data", 64'(bus.spi_data), 64'(exp_data));
        if (tmo_pending) begin
            if (cyc == go_cyc + int'(TMO) - 1) check("timeout_early", 64'(timeout_err), 64'(tmo_flag));
            if (cyc == go_cyc + int'(TMO)) begin
                check("timeout_at", 64'(timeout_err), 1);
                check("timeout_count", 64'(frame_count), 64'(model_count));
                tmo_pending = 0;
                tmo_flag    = 1;
                last_end    = cyc - 1;
                have_end    = 1;
            end
        end
        if (ser_active) begin
            if (cyc == ss_fall) bus.spi_ss_n = 1'b0;
            if (cyc == ss_rise) begin
                check("spi_data_hold", 64'(bus.spi_data), 64'(exp_data));
                bus.spi_ss_n = 1'b1;
                model_count  = (model_count + 1) % 65536;
                last_end     = cyc;
                have_end     = 1;
                ser_active   = 0;
            end
        end
        if (pend && cyc == pend_due) bus.fifo_data = pend_word;
        else                         bus.fifo_data = DW'($urandom);
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic reset_model();
        fifo_q.delete();
        pend = 0; ser_active = 0; tmo_pending = 0; tmo_flag = 0; have_end = 0;
        model_count = 0; data_chk_cyc = -1;
        bus.spi_ss_n   = 1'b1;
        bus.fifo_empty = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_en"}, 64'(bus.fifo_rd_en), 0);
        check({tag, "_go"}, 64'(bus.spi_go), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_tmo"}, 64'(timeout_err), 0);
        check({tag, "_spi_data"}, 64'(bus.spi_data), 0);
        check({tag, "_count"}, 64'(frame_count), 0);
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (n < budget && !(fifo_q.size() == 0 && !ser_active && !tmo_pending &&
                               !busy && !bus.fifo_rd_en && !bus.spi_go)) begin
            step();
            n++;
        end
        check("idle_budget", 64'(n < budget), 1);
    endtask

    initial begin
        int n, pushed, base, start_rd;
        logic [DW-1:0] last_w;
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        bus.spi_ss_n   = 1'b1;

        // Reset and idle
        repeat (3) step();
        check_reset_values("reset");
        rst = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_quiet", {28'd0, bus.fifo_rd_en, bus.spi_go, busy, timeout_err,
                                 frame_count, bus.spi_data}, 0);
        end

        // Single frame
        push_word(16'h00A5);
        run_until_idle(200);
        check("single_count", 64'(frame_count), 1);
        check("single_data", 64'(bus.spi_data), 64'(expect_word(16'h00A5, 0)));

        // Back-to-back frames
        push_word(16'h0001); push_word(16'h0002); push_word(16'h0003);
        run_until_idle(400);
        check("b2b_count", 64'(frame_count), 4);
        check("b2b_last_data", 64'(bus.spi_data), 64'(expect_word(16'h0003, 3)));

        // Start timeout on the first word, second word still served
        ser_respond = 0;
        push_word(16'h1234); push_word(16'h5678);
        n = 0;
        start_rd = go_count;
        while (go_count == start_rd && n < 100) begin step(); n++; end
        check("tmo_go_budget", 64'(n < 100), 1);
        ser_respond = 1;
        run_until_idle(400);
        check("tmo_sticky", 64'(timeout_err), 1);
        check("tmo_after_count", 64'(frame_count), 5);

        // Enable dropped mid-frame: finish it, then stay idle
        push_word(16'hBEEF); push_word(16'hCAFE);
        n = 0;
        start_rd = rd_count;
        while (rd_count == start_rd && n < 100) begin step(); n++; end
        check("en_rd_budget", 64'(n < 100), 1);
        enable = 1'b0;
        repeat (80) step();
        check("en_drop_count", 64'(frame_count), 6);
        check("en_drop_reads", 64'(rd_count - start_rd), 1);
        check("en_drop_busy", 64'(busy), 0);
        check("en_drop_left", 64'(fifo_q.size()), 1);
        enable = 1'b1;
        run_until_idle(200);
        check("en_resume_count", 64'(frame_count), 7);

        // Randomized traffic with enable toggling
        base = model_count;
        pushed = 0;
        for (int i = 0; i < 800; i++) begin
            if (pushed < 20 && $urandom_range(0, 9) == 0) begin
                push_word(DW'($urandom));
                pushed++;
            end
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            step();
        end
        enable = 1'b1;
        run_until_idle(2000);
        check("rand_count", 64'(frame_count), 64'((base + pushed) % 65536));
        check("rand_rd_go", 64'(rd_count), 64'(go_count));

        // Reset during WAIT_DONE abandons the frame
        push_word(16'h0F0F);
        n = 0;
        while (bus.spi_ss_n && n < 100) begin step(); n++; end
        check("mid_ss_budget", 64'(n < 100), 1);
        repeat (5) step();
        rst = 1'b1;
        reset_model();
        repeat (2) step();
        check_reset_values("midrst");
        rst = 1'b0;
        start_rd = rd_count + go_count;
        repeat (20) step();
        check("midrst_quiet", 64'(rd_count + go_count - start_rd), 0);
        check("midrst_count", 64'(frame_count), 0);

        // 17 frames: sequence tag wraps back to 0 on the last one
        for (int i = 0; i < 17; i++) begin
            last_w = DW'($urandom);
            push_word(last_w);
        end
        run_until_idle(17 * 60);
        check("wrap_count", 64'(frame_count), 17);
        check("wrap_last_data", 64'(bus.spi_data), 64'(expect_word(last_w, 16)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/phase_readout_ctrl.md
PHASE_READOUT_CTRL -- requirements
Module: phase_readout_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the FIFO word and SPI frame width.
REQ-002 SHALL have parameter READ_LATENCY, default 2, the cycles from fifo_rd_en to valid fifo_data (non-FWFT FIFO plus output register).
REQ-003 SHALL have parameter GAP_CYCLES, default 4, the idle cycles enforced between SPI frames (1..255).
REQ-004 SHALL have parameter START_TIMEOUT, default 8, the cycles allowed for spi_ss_n to fall after spi_go.
REQ-005 SHALL have port clk  input  1  the single clock (serial/read clock domain); all logic is on posedge clk.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  permits new FIFO reads when high.
REQ-008 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-009 SHALL have port fifo_rd_en  output  1  one-cycle FIFO read strobe.
REQ-010 SHALL have port fifo_data  input  DATA_WIDTH  FIFO read data.
REQ-011 SHALL have port spi_go  output  1  one-cycle start pulse to the SPI serializer.
REQ-012 SHALL have port spi_data  output  DATA_WIDTH  frame word, held stable from spi_go until the frame ends.
REQ-013 SHALL have port spi_ss_n  input  1  serializer slave-select, low while a frame is shifting.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port frame_count  output  16  number of completed frames, wrapping.
REQ-016 SHALL have port timeout_err  output  1  sticky flag set on a start timeout.

Function
REQ-017 SHALL implement the states IDLE, READ, WAIT_DATA, LOAD, WAIT_START, WAIT_DONE and GAP.
REQ-018 IDLE SHALL go to READ when enable=1 and fifo_empty=0; otherwise it SHALL hold.
REQ-019 READ SHALL assert fifo_rd_en for exactly one cycle, then go to WAIT_DATA.
REQ-020 WAIT_DATA SHALL count READ_LATENCY-1 cycles, then go to LOAD.
REQ-021 LOAD SHALL capture fifo_data into the spi_data register, assert spi_go for one cycle, and go to WAIT_START.
REQ-022 WAIT_START SHALL go to WAIT_DONE on spi_ss_n=0.
REQ-023 If WAIT_START spends START_TIMEOUT cycles with spi_ss_n=1, the block SHALL set timeout_err and go to GAP without incrementing frame_count.
REQ-024 WAIT_DONE SHALL, on spi_ss_n=1, increment frame_count (0xFFFF wraps to 0x0000) and go to GAP.
REQ-025 GAP SHALL hold for GAP_CYCLES cycles, then go to IDLE; a FIFO word available at that point SHALL be read on the next cycle.
REQ-026 Minimum fifo_rd_en spacing SHALL therefore be one frame plus GAP_CYCLES+2 cycles; fifo_rd_en SHALL never assert while fifo_empty=1.
REQ-027 If enable drops mid-sequence, the block SHALL finish the current frame and then remain in IDLE.
REQ-028 fifo_empty rising after READ SHALL NOT abort the frame already read.
REQ-029 fifo_rd_en and spi_go SHALL never be high in the same cycle.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL enter IDLE, and fifo_rd_en, spi_go, busy and timeout_err SHALL be 0, spi_data SHALL be all zeros, and frame_count SHALL be 0x0000, all on the next edge.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; no spi_go or fifo_rd_en SHALL follow until rst is released.
REQ-032 timeout_err SHALL be cleared only by rst.

Configuration
REQ-033 With macro PHASE_READOUT_SEQ_TAG_EN defined, spi_data[DATA_WIDTH-1:DATA_WIDTH-4] SHALL carry a 4-bit tag equal to frame_count[3:0] at LOAD, and the lower DATA_WIDTH-4 bits SHALL carry fifo_data[DATA_WIDTH-5:0].
REQ-034 Without PHASE_READOUT_SEQ_TAG_EN, spi_data SHALL equal the captured fifo_data unmodified.

Verification
REQ-035 Reset and idle: rst for 3 cycles, fifo_empty=1 -> all outputs 0 and busy=0 for 20 cycles.
REQ-036 Single frame: enable=1, one word 0x00A5, serializer model pulls ss_n low 2 cycles after go for 16 cycles -> rd_en at cycle t, go at t+2, spi_data=0x00A5 (tagged: 0x00A5 with tag 0), frame_count=1.
REQ-037 Back-to-back: three words 0x0001/0x0002/0x0003 queued -> three frames in order, rd_en pulses separated by at least frame+6 cycles, frame_count=3.
REQ-038 Timeout: ss_n held high -> timeout_err=1 exactly 8 cycles after go, frame_count unchanged, next word is still served.
REQ-039 Mid-frame reset: rst asserted during WAIT_DONE -> IDLE, frame_count=0, no spurious go after release while fifo_empty=1.
REQ-040 Tag wrap (macro on): 17 frames -> tag of frame 17 is 0x0, frame_count=17.
